i_cache: RTL and testbench
==========================

// Module: i_cache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
//  IF presents a PC every cycle. A hit returns the instruction combinationally in the same cycle.
//  A miss runs one word refill through mem_ctrl. The refilled word is forwarded to IF on the
//  return cycle and written into the line.
//  A jump/flush from IF marks any outstanding refill as stale.
// PARAMETERS
//  INDEX_BITS  7  log2(number of lines); default 128 lines x 32-bit
// PORTS
//  clk              in   1          system clock
//  rst              in   1          synchronous, active-high reset
//  addr_i           in   AddrLen    fetch PC from IF; bits [1:0] ignored
//  is_jump_i        in   1          IF flush/redirect; outstanding refill becomes stale
//  inst_available_o out  1          inst_o valid for addr_i this cycle
//  inst_o           out  InstLen    instruction; ZERO_WORD when inst_available_o=0
//  mem_req_o        out  1          refill request to mem_ctrl; held until mem_valid_i
//  mem_addr_o       out  AddrLen    word-aligned refill address; stable while mem_req_o=1
//  mem_valid_i      in   1          one-cycle pulse: mem_inst_i holds the requested word
//  mem_inst_i       in   InstLen    refill data
//  hit_cnt_o        out  32         ICACHE_PERF_EN only: lookup hits
//  miss_cnt_o       out  32         ICACHE_PERF_EN only: misses that started a refill
// BEHAVIOUR
//  - Address split: index = addr_i[INDEX_BITS+1:2]; tag = addr_i[AddrLen-1:INDEX_BITS+2].
//  - Storage: valid[], tag[], data[] reg arrays with asynchronous read.
//    Only valid[] is reset (all 0); tag/data have no reset.
//  - hit = !rst && state==IDLE && valid[idx] && tag[idx]==tag(addr_i).
//  - Forwarding, REFILL state only: fwd = mem_valid_i && !stale && addr_i[AddrLen-1:2]==miss_addr[AddrLen-1:2].
//  - inst_available_o = hit | fwd.
//  - inst_o = data[idx] on hit, mem_inst_i on fwd, else ZERO_WORD.
//  - FSM, 2 states:
//    IDLE:   !rst && !hit -> latch miss_addr={addr_i[AddrLen-1:2],2'b00}; stale<=0; go REFILL.
//            mem_valid_i is ignored in IDLE.
//    REFILL: mem_req_o=1, mem_addr_o=miss_addr. is_jump_i sets stale<=1; the request is not withdrawn.
//            On mem_valid_i: write data/tag, set valid for miss_addr (fill even if stale); go IDLE.
//  - Outputs in IDLE: mem_req_o=0, mem_addr_o=ZERO_WORD.
//  - Latency: hit 0 cycles. Miss detected in cycle N -> mem_req_o=1 from N+1.
//    Data is delivered in the mem_valid_i cycle via fwd. The next lookup is in IDLE.
//  - Simultaneous events:
//    is_jump_i with mem_valid_i -> fill, no fwd.
//    addr_i changes without is_jump_i during REFILL -> no fwd; fill still happens.
//    is_jump_i in IDLE -> no effect.
//  - Reset (any state, including mid-refill):
//    next cycle state=IDLE, all valid=0, stale=0, mem_req_o=0, inst_available_o=0.
//    mem_ctrl shares rst, so no orphaned response.
//  - While rst=1: inst_available_o=0, inst_o=ZERO_WORD.
// CONFIGURATION
//  ICACHE_PERF_EN defined:
//    - hit_cnt_o and miss_cnt_o ports exist.
//    - hit_cnt_o increments on each cycle with hit=1.
//    - miss_cnt_o increments on each IDLE->REFILL transition.
//    - Both are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
//  Undefined: ports and counters absent; the remaining behaviour is identical.
// STRUCTURE
//  - config.vh: AddrLen, InstLen, ZERO_WORD, new ICacheIndexBits default for INDEX_BITS,
//    state encodings ICACHE_IDLE=1'b0, ICACHE_REFILL=1'b1.
//  - No sub-module: arrays, FSM and counters are inline, single always @(posedge clk) plus
//    one combinational lookup block.
// TESTING
//  1. Cold miss: after reset, addr_i=0x100 -> inst_available_o=0, mem_req_o=1, mem_addr_o=0x100
//     next cycle. mem_valid_i with 0x00500093 -> same cycle inst_available_o=1, inst_o=0x00500093.
//     Next cycle at 0x100 -> hit.
//  2. Conflict eviction: fill 0x100, then fetch 0x300 (same index, INDEX_BITS=7) -> miss and
//     refill. Re-fetch 0x100 -> miss again.
//  3. Jump mid-refill: miss at 0x200, pulse is_jump_i, addr_i=0x400, then mem_valid_i ->
//     no inst_available_o. Later fetch 0x200 -> hit; 0x400 misses and refills.
//  4. Reset mid-refill: miss at 0x80, assert rst one cycle before mem_valid_i -> mem_req_o=0 next
//     cycle. Re-fetch 0x100 (previously filled) -> miss.
//  5. Unaligned/held: addr_i=0x102 after 0x100 filled -> hit with 0x100 data.
//     mem_addr_o held constant across a 5-cycle mem_valid_i delay.
//  6. ICACHE_PERF_EN: 3 misses then 10 hit cycles -> miss_cnt_o=3, hit_cnt_o=10.
//     Preload a counter to 0xFFFFFFFF and add one event -> 0.

Source files
------------

// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared configuration for the instruction cache.
//   AddrLen / InstLen   : address and instruction widths
//   ZERO_WORD           : all-zero word driven on idle data/address outputs
//   ICacheIndexBits     : default log2(number of cache lines)
//   icache_state_e      : refill FSM state encoding
package i_cache_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int ICacheIndexBits = 7;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/i_cache.sv
// i_cache: direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
//   A hit returns the instruction combinationally in the lookup cycle. A miss moves to
//   REFILL, requests one word from mem_ctrl and forwards it to IF in the return cycle
//   (unless a jump made the refill stale or IF moved to another PC); the line is always
//   written on return.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr_i, is_jump_i   fetch PC (bits [1:0] ignored), IF redirect
//   inst_available_o    inst_o is valid for addr_i this cycle
//   inst_o              instruction, ZERO_WORD when not available
//   mem_req_o/addr_o    refill request and word-aligned address, held until mem_valid_i
//   mem_valid_i/inst_i  one-cycle refill return and its data
//   hit_cnt_o/miss_cnt_o  lookup-hit and refill-start counters (ICACHE_PERF_EN only)
// Build option: define ICACHE_PERF_EN to add the performance counters.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICacheIndexBits
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AddrLen-1:0] addr_i,
  input  logic               is_jump_i,
  output logic               inst_available_o,
  output logic [InstLen-1:0] inst_o,
  output logic               mem_req_o,
  output logic [AddrLen-1:0] mem_addr_o,
  input  logic               mem_valid_i,
  input  logic [InstLen-1:0] mem_inst_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int Lines   = 1 << INDEX_BITS;
  localparam int TagBits = AddrLen - INDEX_BITS - 2;

  // Line storage: only valid_r is reset; tag/data are qualified by valid_r.
  logic [Lines-1:0]   valid_r;
  logic [TagBits-1:0] tag_r  [Lines];
  logic [InstLen-1:0] data_r [Lines];

  icache_state_e      state_r;
  logic               stale_r;
  logic               mem_req_r;
  // Doubles as the miss address while in REFILL.
  logic [AddrLen-1:0] mem_addr_r;

`ifdef ICACHE_PERF_EN
  logic [31:0]        hit_cnt_r;
  logic [31:0]        miss_cnt_r;
`endif

  logic [INDEX_BITS-1:0] idx_s;
  logic [TagBits-1:0]    tag_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TagBits-1:0]    fill_tag_s;
  logic                  hit_s;
  logic                  fwd_s;
  logic                  unused_s;

  assign idx_s      = addr_i[INDEX_BITS+1:2];
  assign tag_s      = addr_i[AddrLen-1:INDEX_BITS+2];
  assign fill_idx_s = mem_addr_r[INDEX_BITS+1:2];
  assign fill_tag_s = mem_addr_r[AddrLen-1:INDEX_BITS+2];
  assign unused_s   = ^addr_i[1:0];

  // Lookup and forwarding; a same-cycle jump already counts as stale for forwarding.
  always_comb begin
    hit_s  = 1'b0;
    fwd_s  = 1'b0;
    inst_o = ZERO_WORD;
    if (!rst && state_r == ICACHE_IDLE) begin
      hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    end else if (!rst && state_r == ICACHE_REFILL) begin
      fwd_s = mem_valid_i && !stale_r && !is_jump_i &&
              (addr_i[AddrLen-1:2] == mem_addr_r[AddrLen-1:2]);
    end else begin
      hit_s = 1'b0;
      fwd_s = 1'b0;
    end
    if (hit_s) begin
      inst_o = data_r[idx_s];
    end else if (fwd_s) begin
      inst_o = mem_inst_i;
    end else begin
      inst_o = ZERO_WORD;
    end
  end

  assign inst_available_o = hit_s | fwd_s;
  assign mem_req_o        = mem_req_r;
  assign mem_addr_o       = mem_addr_r;
`ifdef ICACHE_PERF_EN
  assign hit_cnt_o        = hit_cnt_r;
  assign miss_cnt_o       = miss_cnt_r;
`endif

  // Refill FSM, line fill, registered request outputs and optional counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ICACHE_IDLE;
      valid_r    <= {Lines{1'b0}};
      stale_r    <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= ZERO_WORD;
`ifdef ICACHE_PERF_EN
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
`endif
    end else begin
      case (state_r)
        ICACHE_IDLE: begin
          if (!hit_s) begin
            state_r    <= ICACHE_REFILL;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {addr_i[AddrLen-1:2], 2'b00};
            stale_r    <= 1'b0;
`ifdef ICACHE_PERF_EN
            miss_cnt_r <= miss_cnt_r + 32'd1;
`endif
          end
        end
        ICACHE_REFILL: begin
          if (is_jump_i) begin
            stale_r <= 1'b1;
          end
          // The line is filled even when stale: the word is still correct for its address.
          if (mem_valid_i) begin
            data_r[fill_idx_s]  <= mem_inst_i;
            tag_r[fill_idx_s]   <= fill_tag_s;
            valid_r[fill_idx_s] <= 1'b1;
            state_r             <= ICACHE_IDLE;
            mem_req_r           <= 1'b0;
            mem_addr_r          <= ZERO_WORD;
          end
        end
        default: begin
          state_r   <= ICACHE_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
`ifdef ICACHE_PERF_EN
      if (hit_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: scoreboard bench for i_cache. Each cycle's stimulus carries the expected
// IF/mem outputs; they are queued when driven and popped when the outputs are sampled
// mid-cycle (combinational lookup results, registered request outputs).
module tb_i_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = 32'h0;
  logic        is_jump_i = 1'b0;
  logic        inst_available_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_inst_i = 32'h0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] D1 = 32'h0050_0093;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] D4 = 32'h4444_4444;
  localparam logic [31:0] D5 = 32'h5555_5555;
  localparam logic [31:0] D6 = 32'h6666_6666;
  localparam logic [31:0] D8 = 32'h8888_8888;
  localparam logic [31:0] Z  = 32'h0;

  typedef struct packed {
    logic        rst;
    logic [31:0] addr;
    logic        jump;
    logic        mv;
    logic [31:0] minst;
    logic        e_av;
    logic [31:0] e_inst;
    logic        e_req;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t exp_q[$];

  i_cache dut (
    .clk              (clk),
    .rst              (rst),
    .addr_i           (addr_i),
    .is_jump_i        (is_jump_i),
    .inst_available_o (inst_available_o),
    .inst_o           (inst_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_valid_i      (mem_valid_i),
    .mem_inst_i       (mem_inst_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic j,
                              input logic mv, input logic [31:0] mi, input logic eav,
                              input logic [31:0] ei, input logic erq, input logic [31:0] ema);
    vec_t v;
    v.rst = r; v.addr = a; v.jump = j; v.mv = mv; v.minst = mi;
    v.e_av = eav; v.e_inst = ei; v.e_req = erq; v.e_maddr = ema;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the clock edge and queue its expectation.
  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; addr_i = v.addr; is_jump_i = v.jump;
    mem_valid_i = v.mv; mem_inst_i = v.minst;
    exp_q.push_back(v);
  endtask

  task automatic test_reset();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, Z,        1'b0, Z, 1'b0, Z));
    v.push_back(mk(1'b1, 32'h100, 1'b0, 1'b1, 32'hDEAD, 1'b0, Z, 1'b0, Z));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

  task automatic test_cold_miss();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,        1'b0, Z,        1'b0, Z));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,        1'b0, Z,        1'b1, 32'h100));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b1, D1,       1'b1, D1,       1'b1, 32'h100));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,        1'b1, D1,       1'b0, Z));
    // mem_valid_i in IDLE is ignored; the miss still starts a refill.
    v.push_back(mk(1'b0, 32'h104, 1'b0, 1'b1, 32'hBAD0, 1'b0, Z,        1'b0, Z));
    v.push_back(mk(1'b0, 32'h104, 1'b0, 1'b0, Z,        1'b0, Z,        1'b1, 32'h104));
    v.push_back(mk(1'b0, 32'h104, 1'b0, 1'b1, D2,       1'b1, D2,       1'b1, 32'h104));
    v.push_back(mk(1'b0, 32'h104, 1'b0, 1'b0, Z,        1'b1, D2,       1'b0, Z));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,        1'b1, D1,       1'b0, Z));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL cold_miss[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

  task automatic test_conflict();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1'b0, 32'h300, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h300, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h300));
    v.push_back(mk(1'b0, 32'h300, 1'b0, 1'b1, D3, 1'b1, D3, 1'b1, 32'h300));
    v.push_back(mk(1'b0, 32'h300, 1'b0, 1'b0, Z,  1'b1, D3, 1'b0, Z));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h100));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b1, D1, 1'b1, D1, 1'b1, 32'h100));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,  1'b1, D1, 1'b0, Z));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL conflict[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

  task automatic test_jump();
    vec_t v[$];
    vec_t e;
    // Jump mid-refill; the return comes back while IF is at the miss PC again: stale, no fwd.
    v.push_back(mk(1'b0, 32'h200, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h400, 1'b1, 1'b0, Z,  1'b0, Z,  1'b1, 32'h200));
    v.push_back(mk(1'b0, 32'h200, 1'b0, 1'b1, D3, 1'b0, Z,  1'b1, 32'h200));
    v.push_back(mk(1'b0, 32'h200, 1'b0, 1'b0, Z,  1'b1, D3, 1'b0, Z));
    v.push_back(mk(1'b0, 32'h400, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h400, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h400));
    v.push_back(mk(1'b0, 32'h400, 1'b0, 1'b1, D4, 1'b1, D4, 1'b1, 32'h400));
    v.push_back(mk(1'b0, 32'h400, 1'b0, 1'b0, Z,  1'b1, D4, 1'b0, Z));
    // Jump in the same cycle as the return: fill, no fwd.
    v.push_back(mk(1'b0, 32'h504, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h504, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h504));
    v.push_back(mk(1'b0, 32'h504, 1'b1, 1'b1, D5, 1'b0, Z,  1'b1, 32'h504));
    v.push_back(mk(1'b0, 32'h504, 1'b0, 1'b0, Z,  1'b1, D5, 1'b0, Z));
    // PC moves without a jump: no fwd, fill still happens; a jump in IDLE changes nothing.
    v.push_back(mk(1'b0, 32'h508, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h508, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h508));
    v.push_back(mk(1'b0, 32'h50C, 1'b0, 1'b1, D6, 1'b0, Z,  1'b1, 32'h508));
    v.push_back(mk(1'b0, 32'h508, 1'b1, 1'b0, Z,  1'b1, D6, 1'b0, Z));
    v.push_back(mk(1'b0, 32'h508, 1'b0, 1'b0, Z,  1'b1, D6, 1'b0, Z));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL jump[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1'b0, 32'h080, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h080, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h080));
    // Request is registered: it drops the cycle after rst.
    v.push_back(mk(1'b1, 32'h080, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h080));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 32'h100));
    v.push_back(mk(1'b0, 32'h100, 1'b0, 1'b1, D1, 1'b1, D1, 1'b1, 32'h100));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

  task automatic test_unaligned_held();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(1'b0, 32'h102, 1'b0, 1'b0, Z,  1'b1, D1, 1'b0, Z));
    v.push_back(mk(1'b0, 32'h103, 1'b0, 1'b0, Z,  1'b1, D1, 1'b0, Z));
    v.push_back(mk(1'b0, 32'h606, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, Z));
    for (int k = 0; k < 5; k++) begin
      v.push_back(mk(1'b0, (k == 2) ? 32'h608 : 32'h606, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h604));
    end
    v.push_back(mk(1'b0, 32'h605, 1'b0, 1'b1, D8, 1'b1, D8, 1'b1, 32'h604));
    v.push_back(mk(1'b0, 32'h604, 1'b0, 1'b0, Z,  1'b1, D8, 1'b0, Z));
    foreach (v[i]) begin
      drive(v[i]);
      #4;
      e = exp_q.pop_front();
      vectors++;
      if ({inst_available_o, inst_o, mem_req_o, mem_addr_o} !== {e.e_av, e.e_inst, e.e_req, e.e_maddr}) begin
        miscompares++;
        $display("FAIL unaligned_held[%0d]: got av=%b inst=%h req=%b maddr=%h, want av=%b inst=%h req=%b maddr=%h",
                 i, inst_available_o, inst_o, mem_req_o, mem_addr_o, e.e_av, e.e_inst, e.e_req, e.e_maddr);
      end
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf_counters();
    vec_t e;
    drive(mk(1'b1, 32'h0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z));
    void'(exp_q.pop_front());
    for (int m = 0; m < 3; m++) begin
      drive(mk(1'b0, 32'h1000 + 32'(m * 4), 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z));
      drive(mk(1'b0, 32'h1000 + 32'(m * 4), 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h1000 + 32'(m * 4)));
      drive(mk(1'b0, 32'h1000 + 32'(m * 4), 1'b0, 1'b1, D2, 1'b1, D2, 1'b1, 32'h1000 + 32'(m * 4)));
    end
    for (int h = 0; h < 10; h++) begin
      drive(mk(1'b0, 32'h1000 + 32'((h % 3) * 4), 1'b0, 1'b0, Z, 1'b1, D2, 1'b0, Z));
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    e = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'd3, 1'b0, 32'd10, 1'b0, Z);
    exp_q.push_back(e);
    e = exp_q.pop_front();
    vectors++;
    if ({miss_cnt_o, hit_cnt_o} !== {e.minst, e.e_inst}) begin
      miscompares++;
      $display("FAIL perf_counts: got miss=%0d hit=%0d, want miss=%0d hit=%0d",
               miss_cnt_o, hit_cnt_o, e.minst, e.e_inst);
    end
    // Inputs still present a hit; preload so the next increment wraps.
    dut.hit_cnt_r = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    vectors++;
    if (hit_cnt_o !== 32'h0) begin
      miscompares++;
      $display("FAIL perf_wrap: got hit=%h, want hit=%h", hit_cnt_o, 32'h0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_jump();
    test_reset_mid_refill();
    test_unaligned_held();
`ifdef ICACHE_PERF_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
